outlier_drain: RTL and testbench

- Downstream consumer of the validation controller's outlier FIFO.
- Pops outlier point indices with the FIFO's 1-cycle read latency and buffers them in a small skid buffer.
- Presents them on a valid/ready stream to the host/DMA side and marks the final beat with last.
- Once the controller reports done and the FIFO is fully drained, closes the frame and reports the total outlier count.

---
 rtl/outlier_drain_pkg.sv | 16 +
 rtl/outlier_drain_if.sv | 26 ++
 rtl/outlier_drain_skid_buf.sv | 39 +++
 rtl/outlier_drain.sv | 131 +++++++++++++
 tb/tb_outlier_drain.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/outlier_drain_pkg.sv
// Shared types and constants for the outlier drain path.
// State encoding, default index width and the empty-frame sentinel.
package outlier_pkg;

  localparam int IDX_W = 16;

  localparam logic [IDX_W-1:0] EMPTY_SENTINEL = '1;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    CLOSE,
    FINISHED
  } state_t;

endpackage

// File: rtl/outlier_drain_if.sv
// Outbound outlier-index stream (valid/ready with last).
// master drives data/valid/last, slave returns ready.
interface outlier_drain_if #(
  parameter int N = 16
);

  logic [N-1:0] m_data;
  logic         m_valid;
  logic         m_ready;
  logic         m_last;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/outlier_drain_skid_buf.sv
// Small circular buffer with occupancy counter.
// Write and pop may happen in the same cycle.
module drain_skid_buf #(
  parameter  int W     = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [AW:0]   occ
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + (AW+1)'(wr_en) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/outlier_drain.sv
// Drains the outlier FIFO into a last-marked stream and counts beats.
// Optional macro OUTLIER_BOUNDS_CHECK_EN drops indices >= frame size.
module outlier_drain
  import outlier_pkg::*;
#(
  parameter int             N              = IDX_W,
  parameter int             BUF_DEPTH      = 4,
  parameter logic [N-1:0]   EMPTY_SENTINEL = {N{1'b1}}
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N-1:0]      fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic              ctrl_done,
  input  logic [2*N-1:0]    point_cloud_size,
  outlier_drain_if.master   m,
  output logic [N-1:0]      outlier_count,
  output logic              finished,
  output logic              range_err
);

  localparam int AW = $clog2(BUF_DEPTH);

  state_t         state;
  state_t         state_nx;
  logic           inflight;
  logic           keep;
  logic           wr_en;
  logic           pop;
  logic           done_empty;
  logic [N-1:0]   head;
  logic [AW:0]    occ;
  logic [AW+1:0]  used;
  logic [N-1:0]   data;
  logic           valid;
  logic           last;

  // Reserve a slot for the word already requested from the FIFO.
  assign used       = {1'b0, occ} + (AW+2)'(inflight);
  assign fifo_rd_en = !reset && !fifo_empty && state != FINISHED
                      && used < (AW+2)'(BUF_DEPTH);
  assign done_empty = ctrl_done && fifo_empty && !inflight;

`ifdef OUTLIER_BOUNDS_CHECK_EN
  logic unused_size_hi;
  assign unused_size_hi = ^point_cloud_size[2*N-1:N];
  assign keep = fifo_dout < point_cloud_size[N-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 range_err <= 1'b0;
    else if (inflight && !keep) range_err <= 1'b1;
  end
`else
  logic unused_size;
  assign unused_size = ^point_cloud_size;
  assign keep        = 1'b1;
  assign range_err   = 1'b0;
`endif

  assign wr_en = inflight && keep;

  drain_skid_buf #(
    .W     (N),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (clock),
    .rst     (reset),
    .wr_en   (wr_en),
    .wr_data (fifo_dout),
    .pop     (pop),
    .head    (head),
    .occ     (occ)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      inflight      <= 1'b0;
      outlier_count <= '0;
    end else begin
      state    <= state_nx;
      inflight <= fifo_rd_en;
      if (pop && outlier_count != '1)
        outlier_count <= outlier_count + 1'b1;
    end
  end

  // The newest entry is held back until close so it can carry last.
  always_comb begin
    state_nx = state;
    valid    = 1'b0;
    last     = 1'b0;
    data     = '0;
    unique case (state)
      IDLE: begin
        if (inflight)        state_nx = DRAIN;
        else if (done_empty) state_nx = CLOSE;
      end
      DRAIN: begin
        if (occ >= (AW+1)'(2)) begin
          valid = 1'b1;
          data  = head;
        end
        if (done_empty) state_nx = CLOSE;
      end
      CLOSE: begin
        valid = 1'b1;
        if (occ != '0) begin
          data = head;
          last = occ == (AW+1)'(1);
        end else begin
          data = EMPTY_SENTINEL;
          last = 1'b1;
        end
        if (m.m_ready && last) state_nx = FINISHED;
      end
      FINISHED: begin
        state_nx = FINISHED;
      end
    endcase
  end

  assign pop      = valid && m.m_ready && occ != '0;
  assign finished = state == FINISHED;

  assign m.m_data  = data;
  assign m.m_valid = valid;
  assign m.m_last  = last;

endmodule

// File: tb/tb_outlier_drain.sv
// Randomized scoreboard bench for outlier_drain.
// Models the upstream FIFO and the expected stream from frame contents.
module tb_outlier_drain;
  import outlier_pkg::*;

  localparam int N = 16;

  typedef struct {
    logic [N-1:0] data;
    logic         last;
  } beat_t;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   fifo_dout = '0;
  logic           fifo_empty = 1'b1;
  logic           fifo_rd_en;
  logic           ctrl_done = 1'b0;
  logic [2*N-1:0] point_cloud_size = 32'd100;
  logic [N-1:0]   outlier_count;
  logic           finished;
  logic           range_err;

  outlier_drain_if #(.N(N)) bus ();

  outlier_drain #(
    .N         (N),
    .BUF_DEPTH (4)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .fifo_dout        (fifo_dout),
    .fifo_empty       (fifo_empty),
    .fifo_rd_en       (fifo_rd_en),
    .ctrl_done        (ctrl_done),
    .point_cloud_size (point_cloud_size),
    .m                (bus.master),
    .outlier_count    (outlier_count),
    .finished         (finished),
    .range_err        (range_err)
  );

  always #5 clock = ~clock;

  beat_t        exp_q[$];
  logic [N-1:0] fq[$];
  logic [N-1:0] push_q[$];
  logic [N-1:0] stim[$];
  int           vectors = 0;
  int           errors = 0;
  int           ready_mode = 1;
  int           pops = 0;
  logic         rd_seen = 1'b0;
  logic         hold_prev = 1'b0;
  logic         last_hs = 1'b0;
  logic [N-1:0] prev_data;
  logic         prev_last;
  beat_t        mon_e;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Upstream FIFO: a pop requested in cycle t shows data in cycle t+1.
  always @(negedge clock) rd_seen = fifo_rd_en;

  always @(posedge clock) begin
    #1;
    if (!reset) begin
      if (rd_seen) begin
        vectors++;
        if (fq.size() == 0) begin
          errors++;
          $display("FAIL rd_when_empty: got pop expected none");
        end else begin
          fifo_dout = fq.pop_front();
          pops++;
        end
      end
      while (push_q.size() > 0) fq.push_back(push_q.pop_front());
      fifo_empty = (fq.size() == 0);
    end
  end

  initial bus.m_ready = 1'b0;
  always @(posedge clock) begin
    #1;
    case (ready_mode)
      0:       bus.m_ready = 1'b0;
      1:       bus.m_ready = 1'b1;
      default: bus.m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clock) begin
    if (reset) begin
      hold_prev = 1'b0;
      last_hs   = 1'b0;
    end else begin
      if (last_hs) check("finished_timing", finished, 1);
      if (hold_prev) begin
        check("stable_valid", bus.m_valid, 1);
        check("stable_data", bus.m_data, prev_data);
        check("stable_last", bus.m_last, prev_last);
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL extra_beat: got %0h expected none", bus.m_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat_data", bus.m_data, mon_e.data);
          check("beat_last", bus.m_last, mon_e.last);
        end
      end
      last_hs   = bus.m_valid && bus.m_ready && bus.m_last;
      hold_prev = bus.m_valid && !bus.m_ready;
      prev_data = bus.m_data;
      prev_last = bus.m_last;
    end
  end

  task automatic apply_reset();
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("rst_valid", bus.m_valid, 0);
    check("rst_last", bus.m_last, 0);
    check("rst_data", bus.m_data, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_finished", finished, 0);
    check("rst_count", outlier_count, 0);
    check("rst_range_err", range_err, 0);
    fq.delete();
    push_q.delete();
    exp_q.delete();
    ctrl_done  = 1'b0;
    fifo_empty = 1'b1;
    fifo_dout  = '0;
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
  endtask

  task automatic feed();
    int n;
    foreach (stim[i]) begin
      push_q.push_back(stim[i]);
      if ($urandom_range(0, 2) == 0)
        repeat ($urandom_range(1, 3)) @(posedge clock);
    end
    n = 0;
    while (push_q.size() > 0 && n < 100) begin
      @(posedge clock);
      n++;
    end
  endtask

  task automatic do_frame(input bit hold);
    logic [N-1:0] kept[$];
    logic         err;
    int           n;
    err = 1'b0;
    foreach (stim[i]) begin
`ifdef OUTLIER_BOUNDS_CHECK_EN
      if (stim[i] >= point_cloud_size[N-1:0]) err = 1'b1;
      else kept.push_back(stim[i]);
`else
      kept.push_back(stim[i]);
`endif
    end
    foreach (kept[i])
      exp_q.push_back('{data: kept[i], last: (i == kept.size() - 1)});
    if (kept.size() == 0)
      exp_q.push_back('{data: EMPTY_SENTINEL, last: 1'b1});
    if (hold) begin
      ready_mode = 0;
      pops = 0;
    end
    feed();
    if (hold) begin
      repeat (20) @(posedge clock);
      check("credit_pops", pops, 4);
      ready_mode = 2;
    end
    repeat ($urandom_range(0, 3)) @(posedge clock);
    @(posedge clock);
    #2 ctrl_done = 1'b1;
    n = 0;
    while (!finished && n < 3000) begin
      @(negedge clock);
      n++;
    end
    check("finished", finished, 1);
    check("drained", exp_q.size(), 0);
    check("outlier_count", outlier_count, kept.size());
    check("range_err", range_err, err);
    check("post_valid", bus.m_valid, 0);
    check("post_rd_en", fifo_rd_en, 0);
    stim.delete();
    apply_reset();
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    apply_reset();
    ready_mode = 1;
    stim = {16'd5, 16'd9, 16'd17};
    do_frame(0);
`ifdef OUTLIER_BOUNDS_CHECK_EN
    stim = {16'd50, 16'd120, 16'd60};
    do_frame(0);
`endif
    do_frame(0);
    for (int i = 0; i < 10; i++) stim.push_back(16'(i * 7 + 3));
    do_frame(1);
    ready_mode = 0;
    for (int i = 0; i < 8; i++) stim.push_back(16'(i + 40));
    feed();
    stim.delete();
    repeat (10) @(posedge clock);
    @(negedge clock);
    check("pre_reset_valid", bus.m_valid, 1);
    apply_reset();
    ready_mode = 2;
    stim = {16'd11, 16'd22};
    do_frame(0);
    for (int f = 0; f < 25; f++) begin
      int k;
      ready_mode = $urandom_range(1, 2);
      k = $urandom_range(0, 12);
`ifdef OUTLIER_BOUNDS_CHECK_EN
      point_cloud_size = 32'($urandom_range(50, 200));
      for (int i = 0; i < k; i++) stim.push_back(16'($urandom_range(0, 255)));
`else
      for (int i = 0; i < k; i++) stim.push_back(16'($urandom_range(0, 999)));
`endif
      do_frame(0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
